// File: rtl/mem_module.sv
// ---------------------------------------------------------------------------
// mem_module
//   Small register-file style memory: 2**ADDR_WIDTH words of DATA_WIDTH bits,
//   one write port and one registered read port on a single clock.
//
//   Ports
//     clk      in   rising-edge clock; all state updates here
//     reset    in   synchronous, active-high; clears every word and dataOut
//     Wen      in   write enable: mem[wrAddr] <= datain
//     Ren      in   read enable: dataOut <= mem[rdAddr] (1-cycle latency)
//     wrAddr   in   write address
//     rdAddr   in   read address
//     datain   in   write data
//     dataOut  out  registered read data; holds while Ren is low
//
//   A same-edge write and read to one address is write-first: dataOut takes
//   the incoming datain. Reads of a different address see pre-edge contents.
// ---------------------------------------------------------------------------
module mem_module #(
  parameter int DATA_WIDTH = 15,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Wen,
  input  logic                  Ren,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataOut
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Bypass the write data when the read hits the word being written.
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    collide = Wen && (wrAddr == rdAddr);
    rd_data = collide ? datain : mem[rdAddr];
  end

  // NOTE: clocked state uses non-blocking assignments so the read below sees
  // the pre-edge memory contents regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the memory is cleared on reset because its contents are
      // architecturally visible after reset; this rules out block-RAM mapping.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dataOut <= '0;
    end else begin
      if (Wen) begin
        mem[wrAddr] <= datain;
      end
      if (Ren) begin
        dataOut <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_module.sv
// ---------------------------------------------------------------------------
// tb_mem_module
//   Directed stimulus for mem_module. The driver issues one operation per
//   clock and pushes the hand-computed dataOut expected after that edge into
//   a scoreboard queue; an independent monitor pops and compares on each
//   falling edge.
// ---------------------------------------------------------------------------
module tb_mem_module;

  localparam int DW = 15;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          Wen;
  logic          Ren;
  logic [AW-1:0] wrAddr;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataOut;

  mem_module #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .Wen     (Wen),
    .Ren     (Ren),
    .wrAddr  (wrAddr),
    .rdAddr  (rdAddr),
    .datain  (datain),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t cur;

  // Monitor: one expected value per driven edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (dataOut !== cur.exp) begin
        errors++;
        $display("FAIL %s: dataOut=0x%04h expected=0x%04h", cur.name, dataOut, cur.exp);
      end
    end
  end

  // Drive one edge's worth of inputs, then queue the expected dataOut.
  task automatic cycle(input logic r, input logic w, input logic rd,
                       input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                       input logic [DW-1:0] din, input logic [DW-1:0] exp,
                       input string name);
    exp_t e;
    @(negedge clk);
    reset  = r;
    Wen    = w;
    Ren    = rd;
    wrAddr = wa;
    rdAddr = ra;
    datain = din;
    @(posedge clk);
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; Wen = 1'b0; Ren = 1'b0;
    wrAddr = '0; rdAddr = '0; datain = '0;

    // Reset (two edges), then every address reads back zero.
    cycle(1, 0, 0, 0, 0, 15'h0000, 15'h0000, "reset0");
    cycle(1, 1, 1, 1, 1, 15'h1234, 15'h0000, "reset1_discard");
    for (int a = 0; a < 8; a++)
      cycle(0, 0, 1, 0, 3'(a), 15'h0000, 15'h0000, $sformatf("rd_zero_%0d", a));

    // Write without read leaves dataOut alone; then read it back.
    cycle(0, 1, 0, 0, 0, 15'h1100, 15'h0000, "wr0_hold");
    cycle(0, 0, 1, 0, 0, 15'h0000, 15'h1100, "rd0");
    cycle(0, 1, 0, 2, 0, 15'h7531, 15'h1100, "wr2_hold");
    cycle(0, 1, 0, 5, 0, 15'h7D01, 15'h1100, "wr5_hold");
    cycle(0, 0, 1, 0, 2, 15'h0000, 15'h7531, "rd2");
    cycle(0, 0, 1, 0, 5, 15'h0000, 15'h7D01, "rd5");
    cycle(0, 0, 1, 0, 0, 15'h0000, 15'h1100, "rd0_again");

    // Simultaneous write/read: same address is write-first, different is old.
    cycle(0, 1, 1, 3, 3, 15'h0ABC, 15'h0ABC, "collide3");
    cycle(0, 1, 1, 4, 2, 15'h0555, 15'h7531, "wr4_rd2");
    cycle(0, 0, 1, 0, 4, 15'h0000, 15'h0555, "rd4");
    cycle(0, 0, 1, 0, 3, 15'h0000, 15'h0ABC, "rd3");

    // Ren low: dataOut holds while rdAddr moves.
    for (int a = 0; a < 8; a++)
      cycle(0, 0, 0, 0, 3'(7 - a), 15'h0000, 15'h0ABC, $sformatf("hold_%0d", a));

    // A write enable pulse that is gone before the edge must not write.
    @(negedge clk);
    Wen = 1'b1; wrAddr = 3'd0; datain = 15'h1234; Ren = 1'b0;
    #2;
    Wen = 1'b0;
    @(posedge clk);
    exp_q.push_back('{15'h0ABC, "glitch_hold"});
    cycle(0, 0, 1, 0, 0, 15'h0000, 15'h1100, "rd0_after_glitch");

    // Back-to-back writes to one address: last one wins.
    cycle(0, 1, 0, 7, 0, 15'h7FFF, 15'h1100, "wr7_a");
    cycle(0, 1, 0, 7, 0, 15'h0001, 15'h1100, "wr7_b");
    cycle(0, 0, 1, 0, 7, 15'h0000, 15'h0001, "rd7");

    // Reset beats a concurrent write/read and clears the array.
    cycle(1, 1, 1, 6, 6, 15'h2222, 15'h0000, "reset_wr6");
    cycle(0, 0, 1, 0, 6, 15'h0000, 15'h0000, "rd6_after_reset");
    cycle(0, 0, 1, 0, 2, 15'h0000, 15'h0000, "rd2_cleared");
    cycle(0, 0, 1, 0, 7, 15'h0000, 15'h0000, "rd7_cleared");
    cycle(0, 1, 1, 1, 1, 15'h0042, 15'h0042, "collide1");
    cycle(0, 0, 1, 0, 1, 15'h0000, 15'h0042, "rd1");

    cycle(0, 0, 0, 0, 0, 15'h0000, 15'h0042, "final_hold");
    Ren = 1'b0; Wen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_module.md
MEM_MODULE -- requirements
Module: mem_module

Interface
REQ-001 DATA_WIDTH, 15, width of each memory word and of datain/dataOut; SHALL be a parameter.
REQ-002 ADDR_WIDTH, 3, address width; depth SHALL be 2**ADDR_WIDTH (8 words at default).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 Wen  input  1  write enable, active-high.
REQ-006 Ren  input  1  read enable, active-high.
REQ-007 wrAddr  input  ADDR_WIDTH  write address.
REQ-008 rdAddr  input  ADDR_WIDTH  read address.
REQ-009 datain  input  DATA_WIDTH  write data.
REQ-010 dataOut  output  DATA_WIDTH  registered read data.

Function
REQ-011 Storage SHALL be an array of 2**ADDR_WIDTH words of DATA_WIDTH bits each; all addresses valid, with no out-of-range case.
REQ-012 Write: at a rising clk with reset=0 and Wen=1, mem[wrAddr] SHALL take datain; with Wen=0 memory SHALL be unchanged.
REQ-013 Write SHALL be independent of Ren; Wen and Ren both high SHALL perform both operations in the same cycle.
REQ-014 Read: at a rising clk with reset=0 and Ren=1, dataOut SHALL take mem[rdAddr]; read latency is 1 cycle.
REQ-015 With Ren=0, dataOut SHALL hold its previous value.
REQ-016 Same-address collision: Wen=1, Ren=1 and wrAddr==rdAddr in one cycle SHALL be write-first; dataOut SHALL take the new datain in that same edge.
REQ-017 Different-address simultaneous read and write SHALL return the pre-edge content of mem[rdAddr].
REQ-018 Back-to-back writes to the same address SHALL leave the last written value; each edge with Wen=1 SHALL be a full write.
REQ-019 dataOut SHALL be driven only from the output register, with no combinational path from any input.
REQ-020 Inputs are sampled only at the rising edge; changes between edges SHALL have no effect.

Reset
REQ-021 At a rising clk with reset=1, every memory word SHALL be cleared to 0 and dataOut SHALL be cleared to 0.
REQ-022 reset SHALL take priority over Wen and Ren; a write or read in a reset cycle SHALL be discarded.
REQ-023 The first cycle after reset is released SHALL accept writes and reads normally.
REQ-024 Before the first reset, memory and dataOut contents are undefined; the bench SHALL apply reset before checking.

Verification
REQ-025 Reset, then read addresses 0..7 with Ren=1 -> dataOut=0 one cycle after each read.
REQ-026 Write 0x1100 to address 0 with Wen=1, Ren=0 -> dataOut unchanged; then read address 0 with Ren=1, Wen=0 -> dataOut=0x1100 after 1 cycle.
REQ-027 Write 30001 (0x7531) to address 2 and 32001 (0x7D01) to address 5 -> reading 2 returns 0x7531 and reading 5 returns 0x7D01; address 0 still returns 0x1100.
REQ-028 Same edge: Wen=1, Ren=1, wrAddr=rdAddr=3, datain=0x0ABC -> dataOut=0x0ABC after that edge; with wrAddr=4, rdAddr=2 -> dataOut=0x7531.
REQ-029 Hold Ren=0 while toggling rdAddr -> dataOut constant; assert reset with Wen=1 writing address 6 -> dataOut=0 and a subsequent read of address 6 returns 0.
REQ-030 Write address 7 with 0x7FFF, then with 0x0001 on the next edge -> reading 7 returns 0x0001.
